// File: rtl/ldm_stm_addr_seq_pkg.sv
// Shared definitions for the LDM/STM address/transfer sequencer.
package ldm_stm_addr_seq_pkg;

    // Byte stride between consecutive transferred registers
    localparam int WORD_BYTES = 4;

    // ir[27:25] value identifying a block data transfer
    localparam logic [2:0] OPC_BLOCK_XFER = 3'b100;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_WB    = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Addressing modes as encoded on {P,U} = ir[24:23]
    typedef enum logic [1:0] {
        MODE_DA = 2'b00,
        MODE_IA = 2'b01,
        MODE_DB = 2'b10,
        MODE_IB = 2'b11
    } mode_e;

endpackage

// File: rtl/ldm_stm_addr_seq_reg_list_scan.sv
// Combinational register-list scanner: lowest set bit, empty flag, popcount.
module ldm_stm_addr_seq_reg_list_scan
    import ldm_stm_addr_seq_pkg::*;
(
    input  logic [15:0] mask,
    output logic [3:0]  lowest_idx,
    output logic        none,
    output logic [4:0]  count
);

    // Walk from the top bit down so the last hit is the lowest set bit
    always_comb begin
        lowest_idx = 4'd0;
        count      = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) begin
                lowest_idx = 4'(i);
            end else begin
                lowest_idx = lowest_idx;
            end
            count = count + {4'd0, mask[i]};
        end
        none = (mask == 16'd0);
    end

endmodule

// File: rtl/ldm_stm_addr_seq.sv
// LDM/STM address sequencer: walks the register list lowest-first, issues one
// memory request per register with ascending addresses, handshakes on moc and
// produces the base writeback value.
module ldm_stm_addr_seq
    import ldm_stm_addr_seq_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int WORD_BYTES = ldm_stm_addr_seq_pkg::WORD_BYTES
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              start,
    input  logic [31:0]       ir,
    input  logic [ADDR_W-1:0] base_val,
    input  logic              moc,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        xfer_reg,
    output logic              xfer_valid,
    output logic              wb_en,
    output logic [3:0]        wb_reg,
    output logic [ADDR_W-1:0] wb_val,
    output logic              done
);

    state_e            state_q, state_d;
    logic [1:0]        pu_q, pu_d;
    logic              w_q, w_d;
    logic              l_q, l_d;
    logic [3:0]        rn_q, rn_d;
    logic [15:0]       mask_q, mask_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wb_val_q, wb_val_d;

    logic [3:0]        lowest_s;
    logic              none_s;
    logic [4:0]        count_s;
    logic [ADDR_W-1:0] stride_s;
    logic [ADDR_W-1:0] span_s;
    logic              unused_s;

    // Condition code and S bit play no part in sequencing
    assign unused_s = ^{ir[31:28], ir[22]};

    ldm_stm_addr_seq_reg_list_scan u_scan (
        .mask       (mask_q),
        .lowest_idx (lowest_s),
        .none       (none_s),
        .count      (count_s)
    );

    assign stride_s = ADDR_W'(WORD_BYTES);
    assign span_s   = ADDR_W'(count_s) * stride_s;

    // Next-state, capture and address arithmetic
    always_comb begin
        state_d  = state_q;
        pu_d     = pu_q;
        w_d      = w_q;
        l_d      = l_q;
        rn_d     = rn_q;
        mask_d   = mask_q;
        base_d   = base_q;
        addr_d   = addr_q;
        wb_val_d = wb_val_q;
        case (state_q)
            ST_IDLE: begin
                if (start && (ir[27:25] == OPC_BLOCK_XFER)) begin
                    pu_d    = ir[24:23];
                    w_d     = ir[21];
                    l_d     = ir[20];
                    rn_d    = ir[19:16];
                    mask_d  = ir[15:0];
                    base_d  = base_val;
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                case (pu_q)
                    MODE_IA: addr_d = base_q;
                    MODE_IB: addr_d = base_q + stride_s;
                    MODE_DA: addr_d = base_q - span_s + stride_s;
                    MODE_DB: addr_d = base_q - span_s;
                    default: addr_d = base_q;
                endcase
                if (pu_q[0]) begin
                    wb_val_d = base_q + span_s;
                end else begin
                    wb_val_d = base_q - span_s;
                end
                if (none_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (moc) begin
                    // Clear the lowest set bit and step to the next word
                    mask_d = mask_q & (mask_q - 16'd1);
                    addr_d = addr_q + stride_s;
                    if ((mask_q & (mask_q - 16'd1)) == 16'd0) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_XFER;
                    end
                end else begin
                    state_d = ST_XFER;
                end
            end
            ST_WB: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            pu_q     <= 2'd0;
            w_q      <= 1'b0;
            l_q      <= 1'b0;
            rn_q     <= 4'd0;
            mask_q   <= 16'd0;
            base_q   <= '0;
            addr_q   <= '0;
            wb_val_q <= '0;
        end else begin
            state_q  <= state_d;
            pu_q     <= pu_d;
            w_q      <= w_d;
            l_q      <= l_d;
            rn_q     <= rn_d;
            mask_q   <= mask_d;
            base_q   <= base_d;
            addr_q   <= addr_d;
            wb_val_q <= wb_val_d;
        end
    end

    // Output decode from the registered state
    always_comb begin
        busy       = (state_q != ST_IDLE);
        mem_req    = (state_q == ST_XFER);
        mem_rw     = (state_q == ST_XFER) ? l_q : 1'b0;
        mem_addr   = addr_q;
        xfer_reg   = (state_q == ST_XFER) ? lowest_s : 4'd0;
        xfer_valid = (state_q == ST_XFER) && moc;
        wb_en      = (state_q == ST_WB) && w_q;
        wb_reg     = rn_q;
        wb_val     = wb_val_q;
        done       = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_ldm_stm_addr_seq.sv
// Self-checking bench for ldm_stm_addr_seq: directed and random block
// transfers checked against a transaction-level reference model.
module tb_ldm_stm_addr_seq;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        start = 1'b0;
    logic [31:0] ir = 32'd0;
    logic [31:0] base_val = 32'd0;
    logic        moc = 1'b0;
    logic        busy, mem_req, mem_rw, xfer_valid, wb_en, done;
    logic [31:0] mem_addr, wb_val;
    logic [3:0]  xfer_reg, wb_reg;

    int vecs = 0;
    int errs = 0;

    ldm_stm_addr_seq #(.ADDR_W(32), .WORD_BYTES(4)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .start(start), .ir(ir),
        .base_val(base_val), .moc(moc), .busy(busy), .mem_req(mem_req),
        .mem_rw(mem_rw), .mem_addr(mem_addr), .xfer_reg(xfer_reg),
        .xfer_valid(xfer_valid), .wb_en(wb_en), .wb_reg(wb_reg),
        .wb_val(wb_val), .done(done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_ir(input bit p, input bit u, input bit w,
                                          input bit l, input logic [3:0] rn,
                                          input logic [15:0] list);
        return {4'hE, 3'b100, p, u, 1'b0, w, l, rn, list};
    endfunction

    task automatic chk_idle_zero(input string tag);
        chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
        chk({tag, ".mem_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, ".mem_rw"}, {31'd0, mem_rw}, 32'd0);
        chk({tag, ".mem_addr"}, mem_addr, 32'd0);
        chk({tag, ".xfer_reg"}, {28'd0, xfer_reg}, 32'd0);
        chk({tag, ".xfer_valid"}, {31'd0, xfer_valid}, 32'd0);
        chk({tag, ".wb_en"}, {31'd0, wb_en}, 32'd0);
        chk({tag, ".wb_reg"}, {28'd0, wb_reg}, 32'd0);
        chk({tag, ".wb_val"}, wb_val, 32'd0);
        chk({tag, ".done"}, {31'd0, done}, 32'd0);
    endtask

    // One complete operation: stall_first >= 0 fixes the moc stall count on the
    // first request, otherwise stalls are random; inject pulses a second start
    // during SETUP, which must be ignored.
    task automatic run_op(input logic [31:0] i_ir, input logic [31:0] base,
                          input int stall_first, input bit inject);
        logic [3:0]  regs[$];
        logic [31:0] lo, span, exp_wb;
        int          n, stalls;
        bit          m;
        n = 0;
        regs.delete();
        for (int i = 0; i < 16; i++) begin
            if (i_ir[i]) begin
                regs.push_back(4'(i));
                n++;
            end
        end
        span = 32'(n) * 32'd4;
        case ({i_ir[24], i_ir[23]})
            2'b01:   lo = base;
            2'b11:   lo = base + 32'd4;
            2'b00:   lo = base - span + 32'd4;
            default: lo = base - span;
        endcase
        exp_wb = i_ir[23] ? base + span : base - span;

        @(negedge CLK);
        start = 1'b1; ir = i_ir; base_val = base; moc = 1'b0;
        @(negedge CLK);
        start = inject;
        ir = mk_ir(1'($urandom), 1'($urandom), 1'b1, 1'($urandom), 4'($urandom), 16'hFFFF);
        base_val = $urandom;
        moc = 1'($urandom);
        #1;
        chk("setup.busy", {31'd0, busy}, 32'd1);
        chk("setup.mem_req", {31'd0, mem_req}, 32'd0);
        chk("setup.done", {31'd0, done}, 32'd0);

        for (int k = 0; k < n; k++) begin
            stalls = 0;
            do begin
                @(negedge CLK);
                start = 1'b0;
                if (k == 0 && stall_first >= 0) m = (stalls >= stall_first);
                else m = (stalls >= 3) || ($urandom_range(0, 3) != 0);
                moc = m;
                #1;
                chk("xfer.mem_req", {31'd0, mem_req}, 32'd1);
                chk("xfer.busy", {31'd0, busy}, 32'd1);
                chk("xfer.mem_addr", mem_addr, lo + 32'(k) * 32'd4);
                chk("xfer.xfer_reg", {28'd0, xfer_reg}, {28'd0, regs[k]});
                chk("xfer.mem_rw", {31'd0, mem_rw}, {31'd0, i_ir[20]});
                chk("xfer.xfer_valid", {31'd0, xfer_valid}, {31'd0, m});
                chk("xfer.wb_en", {31'd0, wb_en}, 32'd0);
                stalls++;
            end while (!m);
        end

        if (n > 0) begin
            @(negedge CLK);
            start = 1'b0; moc = 1'($urandom);
            #1;
            chk("wb.wb_en", {31'd0, wb_en}, {31'd0, i_ir[21]});
            chk("wb.wb_reg", {28'd0, wb_reg}, {28'd0, i_ir[19:16]});
            chk("wb.wb_val", wb_val, exp_wb);
            chk("wb.mem_req", {31'd0, mem_req}, 32'd0);
            chk("wb.done", {31'd0, done}, 32'd0);
        end

        @(negedge CLK);
        start = 1'b0; moc = 1'($urandom);
        #1;
        chk("done.done", {31'd0, done}, 32'd1);
        chk("done.busy", {31'd0, busy}, 32'd1);
        chk("done.wb_en", {31'd0, wb_en}, 32'd0);
        chk("done.mem_req", {31'd0, mem_req}, 32'd0);

        @(negedge CLK);
        moc = 1'b0;
        #1;
        chk("after.busy", {31'd0, busy}, 32'd0);
        chk("after.done", {31'd0, done}, 32'd0);
        chk("after.mem_req", {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        logic [31:0] r_ir, r_base;
        logic [15:0] r_list;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk_idle_zero("reset");
        RESET_N = 1'b1;

        // LDMIA r10!, {r2,r5,r7}, no stalls
        run_op(mk_ir(1'b0, 1'b1, 1'b1, 1'b1, 4'd10, 16'h00A4), 32'h0000_1000, 0, 1'b0);
        // STMDB r13!, {r0,r14}
        run_op(mk_ir(1'b1, 1'b0, 1'b1, 1'b0, 4'd13, 16'h4001), 32'h0000_2000, 0, 1'b0);
        // LDMDA r1, {r1,r3}, three stall cycles on the first request
        run_op(mk_ir(1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 16'h000A), 32'h0000_0100, 3, 1'b0);
        // LDMIB r0!, {r15} from base 0
        run_op(mk_ir(1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 16'h8000), 32'h0000_0000, 0, 1'b0);
        // Empty list
        run_op(mk_ir(1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 16'h0000), 32'h0000_3000, -1, 1'b0);
        // Wrap past the top of the address space, with a start while busy
        run_op(mk_ir(1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 16'h0F00), 32'hFFFF_FFF8, -1, 1'b1);

        // Wrong opcode while idle is ignored
        @(negedge CLK);
        start = 1'b1; ir = 32'hE500_00FF; base_val = 32'h1234_5678;
        @(negedge CLK);
        start = 1'b0;
        repeat (3) begin
            #1;
            chk("badop.busy", {31'd0, busy}, 32'd0);
            chk("badop.mem_req", {31'd0, mem_req}, 32'd0);
            @(negedge CLK);
        end

        // Reset during the second of four transfers
        @(negedge CLK);
        start = 1'b1; ir = mk_ir(1'b0, 1'b1, 1'b1, 1'b1, 4'd4, 16'h1111); base_val = 32'h0000_4000;
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        moc = 1'b1;
        @(negedge CLK);
        moc = 1'b0; RESET_N = 1'b0;
        #1;
        chk("rst.pre_addr", mem_addr, 32'h0000_4004);
        chk("rst.pre_reg", {28'd0, xfer_reg}, 32'd4);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1; moc = 1'b1;
        chk_idle_zero("rst.post");
        repeat (3) begin
            @(negedge CLK);
            chk("rst.no_wb", {31'd0, wb_en}, 32'd0);
            chk("rst.no_done", {31'd0, done}, 32'd0);
        end
        moc = 1'b0;
        run_op(mk_ir(1'b0, 1'b1, 1'b1, 1'b1, 4'd4, 16'h1111), 32'h0000_4000, -1, 1'b0);

        // Random operations
        for (int t = 0; t < 40; t++) begin
            r_list = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            r_ir = mk_ir(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                         4'($urandom), r_list);
            r_base = ($urandom_range(0, 3) == 0) ? {28'hFFFF_FFF, 2'($urandom), 2'b00}
                                                 : {$urandom} & 32'hFFFF_FFFC;
            run_op(r_ir, r_base, -1, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
